// File: rtl/asic_cfg_serializer.sv
// asic_cfg_serializer
//   Shifts a static and a dynamic configuration word to the analog ASIC over
//   sclk/sel/mosi, MSB first, at a runtime half-period. It can optionally
//   re-shift each frame while capturing miso, compare the capture against the
//   latched word, and retry the whole sequence when they differ.
// Ports
//   CLK, RST             clock, asynchronous active-high reset
//   start                one-cycle request, honoured only in IDLE
//   mode                 00/11 static+dynamic, 01 static only, 10 dynamic only
//   verify_en            add a read-back frame after each write frame
//   div_half             sclk half-period in CLK cycles (0 acts as 1)
//   max_retry            retries allowed after the first attempt
//   stat_cfg, dyn_cfg    words to send
//   miso                 ASIC shift-chain output
//   sclk, sel, mosi      ASIC serial interface
//   busy, done, err      sequence status
//   stat_rb, dyn_rb      last verify captures
//   retry_cnt            retries used by the current or last sequence
module asic_cfg_serializer #(
    parameter int STAT_W = 88,
    parameter int DYN_W  = 16,
    parameter int DIV_W  = 8,
    parameter int RTRY_W = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              verify_en,
    input  logic [DIV_W-1:0]  div_half,
    input  logic [RTRY_W-1:0] max_retry,
    input  logic [STAT_W-1:0] stat_cfg,
    input  logic [DYN_W-1:0]  dyn_cfg,
    input  logic              miso,
    output logic              sclk,
    output logic              sel,
    output logic              mosi,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [STAT_W-1:0] stat_rb,
    output logic [DYN_W-1:0]  dyn_rb,
    output logic [RTRY_W-1:0] retry_cnt
);
    localparam int MAX_W = (STAT_W > DYN_W) ? STAT_W : DYN_W;
    localparam int BC_W  = $clog2(MAX_W) + 1;

    // Frame slots within one attempt: 0 S_WR, 1 S_VF, 2 D_WR, 3 D_VF.
    localparam logic [2:0] F_SVF  = 3'd1;
    localparam logic [2:0] F_DVF  = 3'd3;
    localparam logic [2:0] F_NONE = 3'd4;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, CHECK, DONE} state_t;
    typedef logic [MAX_W-1:0] word_t;

    state_t              state;
    logic [1:0]          mode_l;
    logic                ver_l;
    logic [DIV_W-1:0]    half;
    logic [RTRY_W-1:0]   max_l;
    logic [STAT_W-1:0]   stat_l;
    logic [DYN_W-1:0]    dyn_l;
    logic [2:0]          fr;
    logic                restart;
    logic [DIV_W-1:0]    div_cnt;
    logic [DIV_W:0]      gap_cnt;
    logic [BC_W-1:0]     bit_cnt;
    word_t               sh;

    logic                s_on, d_on, gap_end, enter, vf_ok;
    logic [3:0]          fr_en;
    logic [2:0]          base, nxt_fr;
    word_t               nxt_word;
    logic [BC_W-1:0]     nxt_bits;

    always_comb begin
        s_on  = (mode_l != 2'b10);
        d_on  = (mode_l != 2'b01);
        fr_en = {d_on & ver_l, d_on, s_on & ver_l, s_on};
        // Search for the next enabled slot; from LOAD or after a retry the
        // search starts over at slot 0.
        base   = (state == LOAD || restart) ? 3'd0 : fr + 3'd1;
        nxt_fr = F_NONE;
        for (int i = 3; i >= 0; i--)
            if (fr_en[i] && 3'(i) >= base) nxt_fr = 3'(i);
        // Words are left-aligned so mosi is always the shift register MSB.
        if (nxt_fr[1]) begin
            nxt_word = word_t'(dyn_l) << (MAX_W - DYN_W);
            nxt_bits = BC_W'(DYN_W - 1);
        end else begin
            nxt_word = word_t'(stat_l) << (MAX_W - STAT_W);
            nxt_bits = BC_W'(STAT_W - 1);
        end
        gap_end = (gap_cnt == {half, 1'b0} - (DIV_W+1)'(1));
        enter   = (state == LOAD) || (state == GAP && gap_end && nxt_fr != F_NONE);
        vf_ok   = (!(ver_l && s_on) || stat_rb == stat_l) &&
                  (!(ver_l && d_on) || dyn_rb == dyn_l);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            mode_l <= '0; ver_l <= 1'b0; half <= '0; max_l <= '0;
            stat_l <= '0; dyn_l <= '0; fr <= '0; restart <= 1'b0;
            div_cnt <= '0; gap_cnt <= '0; bit_cnt <= '0; sh <= '0;
            sclk <= 1'b0; sel <= 1'b0; mosi <= 1'b0;
            busy <= 1'b0; done <= 1'b0; err <= 1'b0;
            stat_rb <= '0; dyn_rb <= '0; retry_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mode_l    <= mode;
                    ver_l     <= verify_en;
                    half      <= (div_half == '0) ? DIV_W'(1) : div_half;
                    max_l     <= max_retry;
                    stat_l    <= stat_cfg;
                    dyn_l     <= dyn_cfg;
                    restart   <= 1'b0;
                    err       <= 1'b0;
                    retry_cnt <= '0;
                    busy      <= 1'b1;
                    state     <= LOAD;
                end
                LOAD: begin end
                SHIFT: begin
                    if (div_cnt == half - DIV_W'(1)) begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                            if (fr == F_SVF) stat_rb <= {stat_rb[STAT_W-2:0], miso};
                            if (fr == F_DVF) dyn_rb  <= {dyn_rb[DYN_W-2:0], miso};
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == '0) begin
                                sel     <= 1'b0;
                                mosi    <= 1'b0;
                                gap_cnt <= '0;
                                state   <= GAP;
                            end else begin
                                mosi    <= sh[MAX_W-1];
                                sh      <= sh << 1;
                                bit_cnt <= bit_cnt - BC_W'(1);
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        if (nxt_fr == F_NONE) state <= CHECK;
                    end else begin
                        gap_cnt <= gap_cnt + (DIV_W+1)'(1);
                    end
                end
                CHECK: begin
                    if (vf_ok) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (retry_cnt < max_l) begin
                        retry_cnt <= retry_cnt + RTRY_W'(1);
                        restart   <= 1'b1;
                        gap_cnt   <= '0;
                        state     <= GAP;
                    end else begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Frame entry: first bit is presented together with sel rising.
            if (enter) begin
                state   <= SHIFT;
                fr      <= nxt_fr;
                restart <= 1'b0;
                sel     <= 1'b1;
                sclk    <= 1'b0;
                mosi    <= nxt_word[MAX_W-1];
                sh      <= nxt_word << 1;
                bit_cnt <= nxt_bits;
                div_cnt <= '0;
            end
        end
    end
endmodule
